// File: rtl/demorgan_pkg.sv
// Shared definitions for the De Morgan gate self-test checker: state encoding,
// dut_out bit positions and the golden response table.
package demorgan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit positions inside dut_out that the law checks compare.
  localparam int IDX_NAANDNB = 5;
  localparam int IDX_NAB     = 3;
  localparam int IDX_NAORNB  = 2;
  localparam int IDX_NAORB   = 0;

  // Expected byte per vector {A,B}, packed with vector 0 in the low byte.
  localparam logic [31:0] GOLDEN_TABLE = {8'h12, 8'h4E, 8'h8E, 8'hED};

  function automatic logic [7:0] golden(input logic [1:0] vec);
    return GOLDEN_TABLE[{vec, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/demorgan_golden.sv
// Combinational reference: maps a 2-bit {A,B} vector to the expected gate outputs.
module demorgan_golden
  import demorgan_pkg::*;
(
  input  logic [1:0] vec,
  output logic [7:0] expected
);

  assign expected = golden(vec);

endmodule

// File: rtl/demorgan_checker.sv
// Self-sequencing stimulus/checker: sweeps {A,B} through all four vectors,
// samples the gate block outputs after a settle interval and accumulates results.
module demorgan_checker
  import demorgan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ITERATIONS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dut_out,
  output logic       drv_a,
  output logic       drv_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_mask,
  output logic [3:0] mismatch_count,
  output logic [1:0] fail_vec,
  output logic       law1_ok,
  output logic       law2_ok
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_ITER   = 4'(ITERATIONS - 1);

  state_t     state;
  logic [1:0] vec;
  logic [3:0] iter;
  logic [3:0] settle_cnt;
  logic [7:0] expected;
  logic [7:0] diff;
  logic [1:0] vec_next;

  demorgan_golden u_golden (
    .vec      (vec),
    .expected (expected)
  );

  assign diff     = dut_out ^ expected;
  assign vec_next = vec + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      vec            <= 2'd0;
      iter           <= 4'd0;
      settle_cnt     <= 4'd0;
      drv_a          <= 1'b0;
      drv_b          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_mask       <= 8'h00;
      mismatch_count <= 4'd0;
      fail_vec       <= 2'd0;
      law1_ok        <= 1'b1;
      law2_ok        <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_SETTLE;
            vec            <= 2'd0;
            iter           <= 4'd0;
            settle_cnt     <= SETTLE_LOAD;
            drv_a          <= 1'b0;
            drv_b          <= 1'b0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_mask       <= 8'h00;
            mismatch_count <= 4'd0;
            fail_vec       <= 2'd0;
            law1_ok        <= 1'b1;
            law2_ok        <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) state <= ST_SAMPLE;
          else                    settle_cnt <= settle_cnt - 4'd1;
        end
        ST_SAMPLE: begin
          err_mask <= err_mask | diff;
          // mismatch_count still zero means this is the run's first failing vector
          if (diff != 8'h00) begin
            if (mismatch_count != 4'd15) mismatch_count <= mismatch_count + 4'd1;
            if (mismatch_count == 4'd0)  fail_vec <= vec;
          end
          if (dut_out[IDX_NAB] != dut_out[IDX_NAORNB])    law1_ok <= 1'b0;
          if (dut_out[IDX_NAORB] != dut_out[IDX_NAANDNB]) law2_ok <= 1'b0;
          if (vec == 2'd3 && iter == LAST_ITER) begin
            state <= ST_DONE;
          end else begin
            state      <= ST_SETTLE;
            vec        <= vec_next;
            settle_cnt <= SETTLE_LOAD;
            drv_a      <= vec_next[1];
            drv_b      <= vec_next[0];
            if (vec == 2'd3) iter <= iter + 4'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b1;
          pass  <= (err_mask == 8'h00);
          busy  <= 1'b0;
          drv_a <= 1'b0;
          drv_b <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demorgan_checker.sv
// Bench for demorgan_checker: models the gate block with optional fault injection
// and checks run results against a vector-level reference computed in the bench.
module tb_demorgan_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start3;
  logic [7:0] dut_out, dut_out3;
  logic       drv_a, drv_b, busy, done, pass, law1_ok, law2_ok;
  logic [7:0] err_mask;
  logic [3:0] mismatch_count;
  logic [1:0] fail_vec;
  logic       drv_a3, drv_b3, busy3, done3, pass3, law1_ok3, law2_ok3;
  logic [7:0] err_mask3;
  logic [3:0] mismatch_count3;
  logic [1:0] fail_vec3;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int sweep3 = 0;
  logic [1:0] prev3 = 2'd0;

  logic [7:0] xmask [4];
  logic [7:0] and_mask;

  // Ideal gate block, straight from the gate definitions.
  function automatic logic [7:0] ideal(input logic a, input logic b);
    return {~a, ~b, ~a & ~b, a & b, ~(a & b), ~a | ~b, a | b, ~(a | b)};
  endfunction

  assign dut_out  = (ideal(drv_a, drv_b) ^ xmask[{drv_a, drv_b}]) & and_mask;
  assign dut_out3 = ideal(drv_a3, drv_b3) ^
                    ((({drv_a3, drv_b3} == 2'b11) && sweep3 == 2) ? 8'h02 : 8'h00);

  // Counts how many times the ITERATIONS=3 checker has entered vector 11.
  always @(posedge clk) begin
    prev3 <= {drv_a3, drv_b3};
    if (!rst_n) sweep3 <= 0;
    else if ({drv_a3, drv_b3} == 2'b11 && prev3 != 2'b11) sweep3 <= sweep3 + 1;
  end

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  demorgan_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .drv_a(drv_a), .drv_b(drv_b), .busy(busy), .done(done), .pass(pass),
    .err_mask(err_mask), .mismatch_count(mismatch_count), .fail_vec(fail_vec),
    .law1_ok(law1_ok), .law2_ok(law2_ok)
  );

  demorgan_checker #(.SETTLE_CYCLES(2), .ITERATIONS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .dut_out(dut_out3),
    .drv_a(drv_a3), .drv_b(drv_b3), .busy(busy3), .done(done3), .pass(pass3),
    .err_mask(err_mask3), .mismatch_count(mismatch_count3), .fail_vec(fail_vec3),
    .law1_ok(law1_ok3), .law2_ok(law2_ok3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done of the selected checker; returns edges counted after acceptance.
  task automatic wait_done(input bit three, output int lat);
    lat = 0;
    while ((three ? done3 : done) !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, lat);
  endtask

  task automatic check_res(input string tag, input logic [7:0] e_err, input logic [3:0] e_cnt,
                           input logic [1:0] e_fv, input logic e_pass, input logic e_l1,
                           input logic e_l2);
    chk({tag, "_err_mask"}, 32'(err_mask), 32'(e_err));
    chk({tag, "_mismatch_count"}, 32'(mismatch_count), 32'(e_cnt));
    chk({tag, "_fail_vec"}, 32'(fail_vec), 32'(e_fv));
    chk({tag, "_pass"}, 32'(pass), 32'(e_pass));
    chk({tag, "_law1"}, 32'(law1_ok), 32'(e_l1));
    chk({tag, "_law2"}, 32'(law2_ok), 32'(e_l2));
  endtask

  initial begin
    int lat;
    int dc;
    logic [7:0] m_err;
    logic [3:0] m_cnt;
    logic [1:0] m_fv;
    logic       m_l1, m_l2, seen;
    logic [7:0] obs;

    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; and_mask = 8'hFF;
    for (int v = 0; v < 4; v++) xmask[v] = 8'h00;
    tick(); tick();
    chk("reset_drv", 32'({drv_a, drv_b}), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    check_res("reset", 8'h00, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    tick();

    // Ideal run: drive sequence, busy window and latency.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("seq_busy_e0", 32'(busy), 32'd1);
    chk("seq_drv_e0", 32'({drv_a, drv_b}), 32'd0);
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk($sformatf("seq_busy_e%0d", e), 32'(busy), 32'd1);
      chk($sformatf("seq_done_e%0d", e), 32'(done), 32'd0);
      if (e < 12) chk($sformatf("seq_drv_e%0d", e), 32'({drv_a, drv_b}), 32'(e / 3));
    end
    tick();
    chk("seq_done_e13", 32'(done), 32'd1);
    chk("seq_busy_e13", 32'(busy), 32'd0);
    chk("seq_drv_idle", 32'({drv_a, drv_b}), 32'd0);
    check_res("ideal", 8'h00, 4'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("seq_done_pulse_width", 32'(done), 32'd0);

    // nAB stuck at 0.
    and_mask = 8'hF7;
    run(lat);
    chk("stuck_latency", 32'(lat), 32'd13);
    check_res("stuck", 8'h08, 4'd3, 2'd0, 1'b0, 1'b0, 1'b1);
    and_mask = 8'hFF;

    // ITERATIONS=3 with AorB flipped at vector 11 of the second sweep only.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    wait_done(1'b1, lat);
    chk("iter3_latency", 32'(lat), 32'd37);
    chk("iter3_err_mask", 32'(err_mask3), 32'h02);
    chk("iter3_mismatch_count", 32'(mismatch_count3), 32'd1);
    chk("iter3_fail_vec", 32'(fail_vec3), 32'd3);
    chk("iter3_pass", 32'(pass3), 32'd0);
    chk("iter3_laws", 32'({law1_ok3, law2_ok3}), 32'd3);

    // Reset during settle of vector 10 abandons the run.
    and_mask = 8'hF7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("abort_drv_before", 32'({drv_a, drv_b}), 32'd2);
    dc = done_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_drv", 32'({drv_a, drv_b}), 32'd0);
    check_res("abort", 8'h00, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    repeat (20) tick();
    chk("abort_no_done", 32'(done_cnt), 32'(dc));
    and_mask = 8'hFF;
    run(lat);
    chk("after_abort_latency", 32'(lat), 32'd13);
    chk("after_abort_pass", 32'(pass), 32'd1);
    tick();

    // start while busy and during DONE is ignored; start right after DONE is accepted.
    xmask[1] = 8'h40;
    dc = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    start = 1'b1;
    tick();
    tick();
    chk("ignore_done_e13", 32'(done), 32'd1);
    check_res("ignore", 8'h40, 4'd1, 2'd1, 1'b0, 1'b1, 1'b1);
    tick();
    start = 1'b0;
    xmask[1] = 8'h00;
    chk("rerun_done_low", 32'(done), 32'd0);
    chk("rerun_busy", 32'(busy), 32'd1);
    check_res("rerun_cleared", 8'h00, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    wait_done(1'b0, lat);
    chk("rerun_latency", 32'(lat), 32'd13);
    chk("rerun_pass", 32'(pass), 32'd1);
    repeat (3) tick();
    chk("ignore_done_pulses", 32'(done_cnt - dc), 32'd2);

    // Random per-vector fault patterns against a vector-level reference.
    for (int r = 0; r < 8; r++) begin
      for (int v = 0; v < 4; v++)
        xmask[v] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      m_err = 8'h00; m_cnt = 4'd0; m_fv = 2'd0; m_l1 = 1'b1; m_l2 = 1'b1; seen = 1'b0;
      for (int v = 0; v < 4; v++) begin
        obs = ideal(v[1], v[0]) ^ xmask[v];
        m_err |= xmask[v];
        if (xmask[v] != 8'h00) begin
          m_cnt++;
          if (!seen) m_fv = 2'(v);
          seen = 1'b1;
        end
        if (obs[3] != obs[2]) m_l1 = 1'b0;
        if (obs[0] != obs[5]) m_l2 = 1'b0;
      end
      run(lat);
      chk($sformatf("rand%0d_latency", r), 32'(lat), 32'd13);
      check_res($sformatf("rand%0d", r), m_err, m_cnt, m_fv, m_err == 8'h00, m_l1, m_l2);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demorgan_checker.md
Name: demorgan_checker

Overview:
Self-sequencing stimulus/checker for the two-input De Morgan gate block. It drives A/B through all four input vectors, waits a settle interval, samples the block's eight outputs, and compares them against golden values. It accumulates per-output error flags, first-failure information and De Morgan law checks, then reports pass/fail. It is the driving and observing end of the gate block's interface, used for on-bench or FPGA self-test.

Parameters:
SETTLE_CYCLES, 2, cycles drv_a/drv_b are held before sampling; legal range 1..15
ITERATIONS, 1, full 4-vector sweeps per run; legal range 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  run request; accepted only in IDLE
dut_out  input  8  sampled DUT outputs: [7]nA [6]nB [5]nAandnB [4]AandB [3]nAB [2]nAornB [1]AorB [0]nAorB
drv_a  output  1  registered A stimulus to DUT
drv_b  output  1  registered B stimulus to DUT
busy  output  1  high from start acceptance until DONE is left
done  output  1  single-cycle completion pulse
pass  output  1  err_mask==0 at completion; held until next accepted start
err_mask  output  8  sticky per-bit mismatch flags, same bit order as dut_out
mismatch_count  output  4  vectors with any mismatch, saturating at 15
fail_vec  output  2  {A,B} of first mismatching vector; valid when pass=0
law1_ok  output  1  cleared if dut_out[3] != dut_out[2] at any sample (~(AB) == ~A+~B)
law2_ok  output  1  cleared if dut_out[0] != dut_out[5] at any sample (~(A+B) == ~A~B)

Behaviour:
- Reset (rst_n low at an edge): state IDLE, drv_a=drv_b=0, busy=0, done=0, pass=0, err_mask=0, mismatch_count=0, fail_vec=0, law1_ok=law2_ok=1. Reset takes priority over every other event, including mid-run; the run is abandoned with no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 -> SETTLE. Same edge: vec=0, iter=0, drv={0,0}, busy=1, all result outputs cleared to reset values, settle counter=SETTLE_CYCLES-1.
- SETTLE: counter decrements each cycle; at 0 -> SAMPLE.
- SAMPLE (one cycle): exp=golden(vec). diff=dut_out^exp.
  - err_mask|=diff.
  - If diff!=0: mismatch_count saturating +1; if this is the first mismatch of the run, fail_vec=vec.
  - Law flags updated from raw dut_out.
  - If vec==3 and iter==ITERATIONS-1 -> DONE. Otherwise vec+1 (wrapping 3->0; iter+1 on wrap) -> SETTLE, with drv updated to the new vec and the counter reloaded.
- Vector order: {A,B}=00,01,10,11. drv_a=vec[1], drv_b=vec[0].
- Golden bytes: 00->0xED, 01->0x8E, 10->0x4E, 11->0x12.
- DONE (one cycle): done=1, pass=(err_mask==0 including the final sample), busy=0 on exit -> IDLE. drv returns to 00 on entering IDLE.
- Latency: done is high exactly 4*ITERATIONS*(SETTLE_CYCLES+1)+1 cycles after the start-accepting edge. Defaults give 13.
- start in SETTLE/SAMPLE/DONE is ignored; no queuing.
- dut_out is treated as combinational from drv; it is sampled only in SAMPLE.

Decomposition:
- Package demorgan_pkg holds:
  - state encoding,
  - dut_out bit-index constants,
  - golden byte table and golden(vec) function.
- Sub-module demorgan_golden: purely combinational, 2-bit vec -> 8-bit expected. It is reusable by benches as the reference model.

Test Plan:
- Ideal DUT model, defaults, start pulse -> done at cycle 13, pass=1, err_mask=0x00, mismatch_count=0, law1_ok=law2_ok=1.
- drv check, defaults -> drv {a,b} shows 00,01,10,11, each held 3 cycles; busy high 13 cycles; returns to 00 in IDLE.
- nAB (bit3) stuck-at-0 -> vectors 00,01,10 mismatch; err_mask=0x08, mismatch_count=3, fail_vec=00, law1_ok=0, law2_ok=1, pass=0.
- ITERATIONS=3, AorB (bit1) flipped only in sweep 2 at vec 11 -> err_mask=0x02, mismatch_count=1, fail_vec=11, pass=0, done at cycle 37.
- rst_n low during SETTLE of vec 10 -> next edge: busy=0, drv=00, no done pulse, flags reset. A new start with ideal DUT then gives pass=1 at cycle 13.
- start pulsed while busy and again during DONE -> ignored, exactly one done pulse. start the cycle after DONE -> new run accepted, results cleared.
